rf_multiport: RTL and testbench
===============================

RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 SHALL have parameter WSIZE, default 4, bytes per word.
REQ-002 SHALL have parameter AWIDTH, default 5, address bits; DEPTH = 2**AWIDTH words.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 makes word 0 read-only zero.
REQ-005 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port WE  input  WSIZE  per-byte write enable.
REQ-008 SHALL have port AW  input  AWIDTH  write address.
REQ-009 SHALL have port DW  input  WSIZE*8  write data; byte i is DW[8i+7:8i].
REQ-010 SHALL have port AR  input  NRD*AWIDTH  read addresses; port p is AR[(p+1)*AWIDTH-1:p*AWIDTH].
REQ-011 SHALL have port DR  output  NRD*WSIZE*8  registered read data, packed like AR.
REQ-012 SHALL have port READY  output  1  high once post-reset clear is complete.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 SHALL, in CLEAR, write zero to word CNT each cycle, CNT counting 0..DEPTH-1, then move to RUN on the edge that clears word DEPTH-1.
REQ-015 SHALL drive READY=0 in CLEAR and READY=1 in RUN; READY first reads 1 exactly DEPTH edges after the first edge with RST_N=1.
REQ-016 SHALL ignore WE in CLEAR.
REQ-017 SHALL, in RUN, update byte i of word AW at the edge when WE[i]=1; bytes with WE[i]=0 are unchanged.
REQ-018 SHALL, when ZERO_REG=1, ignore writes to address 0 and return 0 for reads of address 0 in all states.
REQ-019 SHALL register read data: DR port p at edge n+1 reflects AR port p sampled at edge n (latency 1).
REQ-020 SHALL hold DR at 0 while READY=0.
REQ-021 SHALL let any number of read ports address the same word simultaneously, with identical results.
REQ-022 SHALL give same-address read/write collisions the behaviour defined in REQ-029/REQ-030.

Reset
REQ-023 SHALL, on any edge with RST_N=0, set state=CLEAR, CNT=0, READY=0, DR=0.
REQ-024 SHALL, on reset asserted mid-CLEAR, restart the clear from word 0.
REQ-025 SHALL, on reset asserted in RUN, discard all contents via a full new clear.
REQ-026 SHALL not rely on the reset value of storage cells; contents are defined only by the clear sweep.

Configuration
REQ-027 SHALL honour macro RF_BYPASS_EN.
REQ-028 SHALL, when RF_BYPASS_EN is defined, forward write data per enabled byte to any read port that addresses AW in the same cycle (write-first).
REQ-029 SHALL, when RF_BYPASS_EN is defined, take non-enabled bytes of a forwarded word from storage.
REQ-030 SHALL, when RF_BYPASS_EN is undefined, return pre-write contents on a same-cycle collision (read-first).
REQ-031 SHALL never forward writes to address 0 when ZERO_REG=1, with or without the macro.

Structure
REQ-032 SHALL place the FSM state enum (CLEAR, RUN) and constant BYTE_W=8 in shared package rf_pkg.
REQ-033 SHALL implement each read port as one instance of sub-module rf_read_port, covering address mux, bypass logic and output register, instantiated NRD times via generate.
REQ-034 SHALL keep the storage array, write decode and clear FSM in rf_multiport.

Verification
REQ-035 Reset, AWIDTH=5: RST_N low 2 cycles, then high -> READY=0 for 32 edges and 1 after the 32nd; reads of words 1..31 return 0.
REQ-036 Byte-enable write: write 0xDEADBEEF to addr 7 with WE=4'b1111, then 0x11223344 with WE=4'b0101 -> read addr 7 returns 0xDE22BE44 one cycle after AR is applied.
REQ-037 Collision: AW=AR0=9, old 0x0, DW=0xCAFEF00D, WE=4'hF -> DR0 = 0xCAFEF00D with RF_BYPASS_EN, 0x00000000 without; next read returns 0xCAFEF00D in both builds.
REQ-038 Zero register: write 0xFFFFFFFF to addr 0 -> both ports reading addr 0 return 0, with and without the macro.
REQ-039 Mid-clear reset: RST_N low at clear word 10, then high -> READY rises exactly 32 edges after release; previously written addr 7 reads 0.
REQ-040 Writes during CLEAR: WE=4'hF, AW=31, DW=0x12345678 at clear word 3 -> addr 31 reads 0 after READY.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the multiport register file.
package rf_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: address mux, optional write-first forwarding, output register.
// Forwarding is compiled in only when RF_BYPASS_EN is defined; otherwise collisions read-first.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WSIZE    = 4,
    parameter int AWIDTH   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ready,
    input  logic [WSIZE*BYTE_W-1:0]   mem [2**AWIDTH],
    input  logic [AWIDTH-1:0]         addr,
`ifdef RF_BYPASS_EN
    input  logic [WSIZE-1:0]          wr_be,
    input  logic [AWIDTH-1:0]         wr_addr,
    input  logic [WSIZE*BYTE_W-1:0]   wr_data,
`endif
    output logic [WSIZE*BYTE_W-1:0]   dr
);

    logic [WSIZE*BYTE_W-1:0] rd_word;

    // wr_be arrives already masked for CLEAR state and for the zero register
    always_comb begin
        rd_word = mem[addr];
`ifdef RF_BYPASS_EN
        for (int i = 0; i < WSIZE; i++) begin
            if (wr_be[i] && (wr_addr == addr)) begin
                rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end
`endif
        if ((ZERO_REG != 0) && (addr == '0)) begin
            rd_word = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ready) begin
            dr <= '0;
        end else begin
            dr <= rd_word;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: byte-enabled write port, NRD registered read ports, post-reset clear sweep.
// Define RF_BYPASS_EN for write-first forwarding on same-address collisions.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int WSIZE    = 4,
    parameter int AWIDTH   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [WSIZE-1:0]            WE,
    input  logic [AWIDTH-1:0]           AW,
    input  logic [WSIZE*BYTE_W-1:0]     DW,
    input  logic [NRD*AWIDTH-1:0]       AR,
    output logic [NRD*WSIZE*BYTE_W-1:0] DR,
    output logic                        READY
);

    localparam int DEPTH = 2**AWIDTH;
    localparam int W     = WSIZE*BYTE_W;

    rf_state_e         state, state_nxt;
    logic [AWIDTH-1:0] cnt, cnt_nxt;
    logic [WSIZE-1:0]  wr_be;
    logic [W-1:0]      mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + AWIDTH'(1);
                if (cnt == AWIDTH'(DEPTH-1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign READY = (state == RUN);

    // Effective byte enables: no writes outside RUN, during reset, or to the zero register
    assign wr_be = (RST_N && (state == RUN) && !((ZERO_REG != 0) && (AW == '0))) ? WE : '0;

    // Storage has no reset; the clear sweep defines its contents
    always_ff @(posedge CLK) begin
        if (RST_N && (state == CLEAR)) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < WSIZE; i++) begin
                if (wr_be[i]) begin
                    mem[AW][i*BYTE_W +: BYTE_W] <= DW[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rf_read_port #(
            .WSIZE    (WSIZE),
            .AWIDTH   (AWIDTH),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .clk     (CLK),
            .rst_n   (RST_N),
            .ready   (READY),
            .mem     (mem),
            .addr    (AR[p*AWIDTH +: AWIDTH]),
`ifdef RF_BYPASS_EN
            .wr_be   (wr_be),
            .wr_addr (AW),
            .wr_data (DW),
`endif
            .dr      (DR[p*W +: W])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (default parameters, both RF_BYPASS_EN builds).
module tb_rf_multiport;

    localparam int WSIZE  = 4;
    localparam int AWIDTH = 5;
    localparam int NRD    = 2;

    logic              CLK;
    logic              RST_N;
    logic [WSIZE-1:0]  WE;
    logic [AWIDTH-1:0] AW;
    logic [31:0]       DW;
    logic [2*AWIDTH-1:0] AR;
    logic [63:0]       DR;
    logic              READY;

    int checks = 0;
    int errors = 0;
    int edges;

    rf_multiport #(
        .WSIZE    (WSIZE),
        .AWIDTH   (AWIDTH),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .WE    (WE),
        .AW    (AW),
        .DW    (DW),
        .AR    (AR),
        .DR    (DR),
        .READY (READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] we, input logic [4:0] aw,
                                 input logic [31:0] dw, input logic [4:0] ar0,
                                 input logic [4:0] ar1);
        WE = we;
        AW = aw;
        DW = dw;
        AR = {ar1, ar0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Counts edges from RST_N release until READY, bounded so a stuck FSM still terminates
    task automatic waitReady(input int start, output int n);
        n = start;
        while (!READY && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [31:0] coll_exp;
        logic [31:0] part_exp;

        RST_N = 1'b0;
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        tick();
        checkOutput("reset_ready", {31'b0, READY}, 32'h0);
        checkOutput("reset_dr0", DR[31:0], 32'h0);
        checkOutput("reset_dr1", DR[63:32], 32'h0);

        // First clear sweep, with a write attempted while word 3 is being cleared
        RST_N = 1'b1;
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd5, 5'd6);
        tick();
        tick();
        tick();
        checkOutput("clear_ready_low", {31'b0, READY}, 32'h0);
        applyStimulus(4'hF, 5'd31, 32'h12345678, 5'd31, 5'd31);
        tick();
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd5, 5'd6);
        checkOutput("clear_dr_held", DR[31:0], 32'h0);
        tick();
        tick();
        checkOutput("clear_ready_still_low", {31'b0, READY}, 32'h0);
        waitReady(6, edges);
        checkOutput("ready_edges", edges, 32'd32);
        checkOutput("ready_high", {31'b0, READY}, 32'h1);

        for (int a = 1; a < 32; a++) begin
            applyStimulus(4'h0, 5'd0, 32'h0, 5'(a), 5'(32 - a));
            tick();
            checkOutput("clear_read_p0", DR[31:0], 32'h0);
            checkOutput("clear_read_p1", DR[63:32], 32'h0);
        end
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd31, 5'd31);
        tick();
        checkOutput("clear_write_ignored", DR[31:0], 32'h0);

        // Byte-enable write
        applyStimulus(4'hF, 5'd7, 32'hDEADBEEF, 5'd1, 5'd1);
        tick();
        applyStimulus(4'h5, 5'd7, 32'h11223344, 5'd1, 5'd1);
        tick();
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd7, 5'd7);
        checkOutput("latency_before", DR[31:0], 32'h0);
        tick();
        checkOutput("byte_en_p0", DR[31:0], 32'hDE22BE44);
        checkOutput("byte_en_p1", DR[63:32], 32'hDE22BE44);

        // Full-word collision, then partial-byte collision
`ifdef RF_BYPASS_EN
        coll_exp = 32'hCAFEF00D;
        part_exp = 32'hCAFEAAAA;
`else
        coll_exp = 32'h00000000;
        part_exp = 32'hCAFEF00D;
`endif
        applyStimulus(4'hF, 5'd9, 32'hCAFEF00D, 5'd9, 5'd7);
        tick();
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd9, 5'd9);
        checkOutput("collision", DR[31:0], coll_exp);
        checkOutput("collision_other_port", DR[63:32], 32'hDE22BE44);
        tick();
        checkOutput("after_collision", DR[31:0], 32'hCAFEF00D);
        applyStimulus(4'h3, 5'd9, 32'h5555AAAA, 5'd7, 5'd9);
        tick();
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd9, 5'd9);
        checkOutput("partial_collision", DR[63:32], part_exp);
        tick();
        checkOutput("after_partial", DR[31:0], 32'hCAFEAAAA);

        // Zero register
        applyStimulus(4'hF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        tick();
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("zero_bypass_p0", DR[31:0], 32'h0);
        checkOutput("zero_bypass_p1", DR[63:32], 32'h0);
        tick();
        checkOutput("zero_read_p0", DR[31:0], 32'h0);
        checkOutput("zero_read_p1", DR[63:32], 32'h0);

        // Reset in RUN, then a second reset at clear word 10
        applyStimulus(4'h0, 5'd0, 32'h0, 5'd7, 5'd9);
        tick();
        checkOutput("pre_reset_read", DR[31:0], 32'hDE22BE44);
        RST_N = 1'b0;
        tick();
        checkOutput("run_reset_ready", {31'b0, READY}, 32'h0);
        checkOutput("run_reset_dr0", DR[31:0], 32'h0);
        checkOutput("run_reset_dr1", DR[63:32], 32'h0);
        RST_N = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        checkOutput("midclear_ready_low", {31'b0, READY}, 32'h0);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        waitReady(0, edges);
        checkOutput("midclear_ready_edges", edges, 32'd32);
        tick();
        checkOutput("midclear_addr7", DR[31:0], 32'h0);
        checkOutput("midclear_addr9", DR[63:32], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
